// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester packet arbiter.
// Holds the FSM state encoding and the helper that picks a winner when idle.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam logic ARB_SEL_REQ0 = 1'b0;
  localparam logic ARB_SEL_REQ1 = 1'b1;

  // A lone requester wins outright; a tie goes to the round-robin pointer.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic prio);
    if (v0 && v1) begin
      return prio;
    end else if (v1) begin
      return ARB_SEL_REQ1;
    end else begin
      return ARB_SEL_REQ0;
    end
  endfunction

endpackage

// File: rtl/mux_arbiter_mux_w.sv
// Bit-level 2:1 mux cell and a DATA_W-wide select built from one cell per bit.
// The arbiter's data, valid and last paths are all steered through these cells.
module mux2 (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic y_o
);

  assign y_o = s_i ? b_i : a_i;

endmodule

module mux_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    mux2 u_mux2 (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .s_i (sel_i),
      .y_o (y_o[i])
    );
  end

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester packet arbiter driving one shared valid/ready channel.
// Define ARB_TIMEOUT_EN to release a grant whose owner stays idle for TIMEOUT cycles.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy,
  output logic              timeout
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mux_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_t state_q, state_d;
  logic       prio_q, prio_d;
  logic       sel_q, sel_d;

  logic              mux_valid;
  logic              mux_last;
  logic [DATA_W-1:0] mux_data;
  logic              xfer;
  logic              idle_expire;

  // sel_q only changes on grant entry, so in ARB_GNTn these carry requester n.
  mux_w #(.W(DATA_W)) u_data_mux (
    .a_i   (req0_data),
    .b_i   (req1_data),
    .sel_i (sel_q),
    .y_o   (mux_data)
  );

  mux2 u_valid_mux (
    .a_i (req0_valid),
    .b_i (req1_valid),
    .s_i (sel_q),
    .y_o (mux_valid)
  );

  mux2 u_last_mux (
    .a_i (req0_last),
    .b_i (req1_last),
    .s_i (sel_q),
    .y_o (mux_last)
  );

  assign busy       = (state_q != ARB_IDLE);
  assign out_valid  = busy & mux_valid;
  assign out_data   = mux_data;
  assign req0_ready = (state_q == ARB_GNT0) & out_ready;
  assign req1_ready = (state_q == ARB_GNT1) & out_ready;
  assign sel        = sel_q;
  assign xfer       = out_valid & out_ready;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             timeout_q;

  // Counts consecutive owner-idle cycles; any valid beat from the owner restarts it.
  always_comb begin
    idle_cnt_d  = '0;
    idle_expire = 1'b0;
    if (busy && !mux_valid) begin
      if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
        idle_expire = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= idle_expire;
    end
  end

  assign timeout = timeout_q;
`else
  assign idle_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    sel_d   = sel_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (req0_valid || req1_valid) begin
          sel_d   = pick_grant(req0_valid, req1_valid, prio_q);
          state_d = (sel_d == ARB_SEL_REQ1) ? ARB_GNT1 : ARB_GNT0;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        // Either ending the packet or timing out hands priority to the other side.
        if ((xfer && mux_last) || idle_expire) begin
          state_d = ARB_IDLE;
          prio_d  = ~sel_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      prio_q  <= ARB_SEL_REQ0;
      sel_q   <= ARB_SEL_REQ0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: a grant/priority model checked every cycle,
// plus directed packet scenarios with literal expectations (timeout scenario follows ARB_TIMEOUT_EN).
module tb_mux_arbiter;

  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_last, req0_ready;
  logic          req1_valid, req1_last, req1_ready;
  logic [DW-1:0] req0_data, req1_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          sel, busy, timeout;

  always #5 clk = ~clk;

  mux_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .sel        (sel),
    .busy       (busy),
    .timeout    (timeout)
  );

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    int            who;
    logic [DW-1:0] data;
  } beat_t;

  beat_t dutBeats[$];
  logic  selLog[$];
  logic  busyLog[$];
  logic  validLog[$];
  logic  toLog[$];

  // Model: who owns the channel (-1 = nobody), the tie-break pointer, and the idle run.
  int mGrant    = -1;
  int mPrio     = 0;
  int mSel      = 0;
  int mTimeout  = 0;
  int mIdle     = 0;
  bit modelLive = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    int   g;
    logic v, l;
    g        = mGrant;
    mTimeout = 0;
    if (rst) begin
      mGrant    = -1;
      mPrio     = 0;
      mSel      = 0;
      mIdle     = 0;
      modelLive = 1'b1;
    end else if (g < 0) begin
      if (req0_valid && req1_valid) mGrant = mPrio;
      else if (req0_valid)          mGrant = 0;
      else if (req1_valid)          mGrant = 1;
      if (mGrant >= 0) mSel = mGrant;
      mIdle = 0;
    end else begin
      v = (g == 1) ? req1_valid : req0_valid;
      l = (g == 1) ? req1_last  : req0_last;
      if (v && out_ready && l) begin
        mGrant = -1;
        mPrio  = 1 - g;
        mIdle  = 0;
      end else if (v) begin
        mIdle = 0;
      end
`ifdef ARB_TIMEOUT_EN
      else begin
        mIdle++;
        if (mIdle == TO) begin
          mGrant   = -1;
          mPrio    = 1 - g;
          mTimeout = 1;
          mIdle    = 0;
        end
      end
`endif
    end
  end

  always @(negedge clk) begin
    logic          eV, eR0, eR1;
    logic [DW-1:0] eD;
    if (modelLive) begin
      eV  = (mGrant == 0) ? req0_valid : (mGrant == 1) ? req1_valid : 1'b0;
      eD  = (mGrant == 1) ? req1_data : req0_data;
      eR0 = (mGrant == 0) && out_ready;
      eR1 = (mGrant == 1) && out_ready;
      checkOutput("out_valid", 32'(out_valid), 32'(eV));
      if (eV) checkOutput("out_data", 32'(out_data), 32'(eD));
      checkOutput("req0_ready", 32'(req0_ready), 32'(eR0));
      checkOutput("req1_ready", 32'(req1_ready), 32'(eR1));
      checkOutput("busy", 32'(busy), 32'(mGrant >= 0));
      checkOutput("sel", 32'(sel), 32'(mSel));
      checkOutput("timeout", 32'(timeout), 32'(mTimeout));
      selLog.push_back(sel);
      busyLog.push_back(busy);
      validLog.push_back(out_valid);
      toLog.push_back(timeout);
      if (out_valid && out_ready) dutBeats.push_back('{who: int'(sel), data: out_data});
    end
  end

  task automatic applyStimulus(input logic v0, input logic [DW-1:0] d0, input logic l0,
                               input logic v1, input logic [DW-1:0] d1, input logic l1,
                               input logic ordy);
    req0_valid = v0;
    req0_data  = d0;
    req0_last  = l0;
    req1_valid = v1;
    req1_data  = d1;
    req1_last  = l1;
    out_ready  = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    dutBeats.delete();
    selLog.delete();
    busyLog.delete();
    validLog.delete();
    toLog.delete();
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    rst = 1'b0;
  endtask

  task automatic checkBeat(input string tag, input int idx, input int expWho, input logic [DW-1:0] expData);
    if (idx < dutBeats.size()) begin
      checkOutput({tag, " who"}, 32'(dutBeats[idx].who), 32'(expWho));
      checkOutput({tag, " data"}, 32'(dutBeats[idx].data), 32'(expData));
    end else begin
      checkOutput({tag, " beat count"}, 32'(dutBeats.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    rst = 1'b0;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset sel", 32'(sel), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);

    // Lone req0 three-beat packet at full throughput.
    clearLogs();
    applyStimulus(1, 8'hA1, 0, 0, 8'h00, 0, 1);
    applyStimulus(1, 8'hA1, 0, 0, 8'h00, 0, 1);
    applyStimulus(1, 8'hA2, 0, 0, 8'h00, 0, 1);
    applyStimulus(1, 8'hA3, 1, 0, 8'h00, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkOutput("A beats", 32'(dutBeats.size()), 32'd3);
    checkBeat("A0", 0, 0, 8'hA1);
    checkBeat("A1", 1, 0, 8'hA2);
    checkBeat("A2", 2, 0, 8'hA3);
    checkOutput("A busy during", 32'(busyLog[3]), 32'd1);
    checkOutput("A busy dead", 32'(busyLog[4]), 32'd0);

    // Both requesters always valid with single-beat packets; priority starts at req0.
    resetDut();
    clearLogs();
    for (int i = 0; i < 8; i++) applyStimulus(1, 8'h10, 1, 1, 8'h20, 1, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkOutput("B beats", 32'(dutBeats.size()), 32'd4);
    checkBeat("B0", 0, 0, 8'h10);
    checkBeat("B1", 1, 1, 8'h20);
    checkBeat("B2", 2, 0, 8'h10);
    checkBeat("B3", 3, 1, 8'h20);
    for (int i = 0; i < 8; i++) checkOutput("B busy pattern", 32'(busyLog[i]), 32'(i % 2));
    checkOutput("B sel holds idle", 32'(selLog[4]), 32'd1);

    // Downstream stalls five cycles in the middle of a req0 packet.
    resetDut();
    clearLogs();
    applyStimulus(1, 8'hC1, 0, 0, 8'h00, 0, 1);
    applyStimulus(1, 8'hC1, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'hC2, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 8'hC2, 0, 0, 8'h00, 0, 1);
    applyStimulus(1, 8'hC3, 1, 0, 8'h00, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkOutput("C beats", 32'(dutBeats.size()), 32'd3);
    checkBeat("C0", 0, 0, 8'hC1);
    checkBeat("C1", 1, 0, 8'hC2);
    checkBeat("C2", 2, 0, 8'hC3);
    checkOutput("C busy in stall", 32'(busyLog[6]), 32'd1);

    // req1 shows up mid-packet and must wait for req0's last beat plus the dead cycle.
    clearLogs();
    applyStimulus(1, 8'hD1, 0, 0, 8'h00, 0, 1);
    applyStimulus(1, 8'hD1, 0, 1, 8'hE1, 1, 1);
    applyStimulus(1, 8'hD2, 1, 1, 8'hE1, 1, 1);
    applyStimulus(0, 8'h00, 0, 1, 8'hE1, 1, 1);
    applyStimulus(0, 8'h00, 0, 1, 8'hE1, 1, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkBeat("D0", 0, 0, 8'hD1);
    checkBeat("D1", 1, 0, 8'hD2);
    checkBeat("D2", 2, 1, 8'hE1);
    checkOutput("D dead cycle", 32'(busyLog[3]), 32'd0);
    checkOutput("D req1 granted", 32'(selLog[4]), 32'd1);

    // Reset lands on the second beat of a req1 packet.
    clearLogs();
    applyStimulus(0, 8'h00, 0, 1, 8'hF1, 0, 1);
    applyStimulus(0, 8'h00, 0, 1, 8'hF1, 0, 1);
    rst = 1'b1;
    applyStimulus(0, 8'h00, 0, 1, 8'hF2, 0, 1);
    rst = 1'b0;
    applyStimulus(0, 8'h00, 0, 1, 8'hF2, 1, 1);
    applyStimulus(0, 8'h00, 0, 1, 8'hF2, 1, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkOutput("E sel after rst", 32'(selLog[3]), 32'd0);
    checkOutput("E busy after rst", 32'(busyLog[3]), 32'd0);
    checkOutput("E valid after rst", 32'(validLog[3]), 32'd0);
    checkBeat("E0", 0, 1, 8'hF1);
    checkBeat("E1", 1, 1, 8'hF2);
    checkBeat("E2", 2, 1, 8'hF2);

    // req0 goes quiet after one non-last beat while req1 waits.
    resetDut();
    clearLogs();
    applyStimulus(1, 8'h61, 0, 0, 8'h00, 0, 1);
    applyStimulus(1, 8'h61, 0, 0, 8'h00, 0, 1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 0, 1, 8'h71, 1, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkOutput("F no early timeout", 32'(toLog[5]), 32'd0);
    checkOutput("F timeout pulse", 32'(toLog[6]), 32'd1);
    checkOutput("F pulse width", 32'(toLog[7]), 32'd0);
    checkOutput("F busy held", 32'(busyLog[5]), 32'd1);
    checkOutput("F busy released", 32'(busyLog[6]), 32'd0);
    checkOutput("F req1 granted", 32'(selLog[7]), 32'd1);
    checkBeat("F0", 0, 0, 8'h61);
    checkBeat("F1", 1, 1, 8'h71);
`else
    for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 0, 1, 8'h71, 1, 1);
    applyStimulus(1, 8'h62, 1, 1, 8'h71, 1, 1);
    applyStimulus(0, 8'h00, 0, 1, 8'h71, 1, 1);
    applyStimulus(0, 8'h00, 0, 1, 8'h71, 1, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkOutput("F no timeout", 32'(toLog[6]), 32'd0);
    checkOutput("F grant held", 32'(busyLog[7]), 32'd1);
    checkBeat("F0", 0, 0, 8'h61);
    checkBeat("F1", 1, 0, 8'h62);
    checkBeat("F2", 2, 1, 8'h71);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: payload width of each requester and of the shared output.
REQ-002 Parameter TIMEOUT, default 16: idle cycles tolerated while a grant is held (used only with ARB_TIMEOUT_EN).
REQ-003 Port clk, in, 1: single clock; all state on rising edge.
REQ-004 Port rst, in, 1: synchronous, active-high reset.
REQ-005 Port req0_valid / req1_valid, in, 1 each: requester has a beat.
REQ-006 Port req0_data / req1_data, in, DATA_W each: requester payload.
REQ-007 Port req0_last / req1_last, in, 1 each: beat ends the requester's packet.
REQ-008 Port req0_ready / req1_ready, out, 1 each: beat accepted this cycle.
REQ-009 Port out_valid, out, 1: shared channel beat valid.
REQ-010 Port out_data, out, DATA_W: shared channel payload.
REQ-011 Port out_ready, in, 1: downstream accepts the beat.
REQ-012 Port sel, out, 1: registered mux select, 0 = req0 and 1 = req1.
REQ-013 Port busy, out, 1: a grant is held.
REQ-014 Port timeout, out, 1: one-cycle pulse when a grant is forcibly released.

Function
REQ-015 FSM states SHALL be ARB_IDLE, ARB_GNT0 and ARB_GNT1.
REQ-016 In ARB_IDLE, the FSM SHALL go to ARB_GNT0 or ARB_GNT1 at the next edge if any reqN_valid=1; with a single valid requester it SHALL grant that one; with both valid it SHALL grant the one named by the round-robin pointer prio.
REQ-017 In ARB_IDLE, out_valid, req0_ready and req1_ready SHALL be 0.
REQ-018 In ARB_GNTn:
- out_valid = reqn_valid
- out_data = reqn_data
- reqn_ready = out_ready
- the other requester's ready = 0
- all of the above combinational, 0 added cycles.
REQ-019 A transfer SHALL be defined as out_valid & out_ready.
REQ-020 A transfer with reqn_last=1 SHALL:
- return the FSM to ARB_IDLE at the next edge, giving exactly one dead cycle between packets
- set prio to the other requester.
REQ-021 Grant SHALL be held across stalls: out_ready=0 or reqn_valid=0 without timeout keeps ARB_GNTn.
REQ-022 sel SHALL be updated only on entry to ARB_GNTn and SHALL hold its value in ARB_IDLE.
REQ-023 busy SHALL be 1 exactly in ARB_GNT0/ARB_GNT1.
REQ-024 Requests arriving during a grant SHALL be ignored until ARB_IDLE; a request SHALL never be dropped, it is only deferred.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL set: state=ARB_IDLE, prio=0, sel=0, timeout=0, idle counter=0.
REQ-026 Outputs following rst: out_valid=0, req0_ready=0, req1_ready=0, busy=0.
REQ-027 rst asserted mid-packet SHALL abandon the packet with no further ready to either requester.

Configuration
REQ-028 With macro ARB_TIMEOUT_EN defined, the idle counter SHALL behave as follows:
- width $clog2(TIMEOUT+1)
- counts cycles in ARB_GNTn with reqn_valid=0
- clears on any cycle with reqn_valid=1
- on reaching TIMEOUT, the FSM SHALL go to ARB_IDLE, timeout SHALL pulse for 1 cycle and prio SHALL flip.
REQ-029 Without ARB_TIMEOUT_EN, there SHALL be no counter, timeout SHALL be tied to 0 and grants SHALL be held indefinitely.

Structure
REQ-030 Package mux_arb_pkg SHALL hold typedef enum arb_state_t and constant ARB_SEL_REQ0=1'b0 / ARB_SEL_REQ1=1'b1.
REQ-031 The data path SHALL use a sub-module mux_w, a DATA_W-wide 2:1 select built from per-bit 2:1 mux instances; valid and last SHALL use single-bit mux instances.

Verification
REQ-032 Scenario: only req0 valid, 3-beat packet 0xA1,0xA2,0xA3 (last on 3rd), out_ready=1 -> sel=0, out_data sequence A1,A2,A3 on 3 consecutive cycles, then busy=0 for 1 cycle.
REQ-033 Scenario: both requesters valid continuously with 1-beat packets -> grants alternate 0,1,0,1; sel toggles each packet; one idle cycle between packets.
REQ-034 Scenario: out_ready held 0 for 5 cycles mid-packet -> grant held, reqn_ready=0, out_data stable, no beat lost or duplicated.
REQ-035 Scenario: req1 raises valid during a req0 packet -> req1_ready stays 0 until req0's last beat, then req1 is granted after the dead cycle.
REQ-036 Scenario, ARB_TIMEOUT_EN with TIMEOUT=4: req0 drops valid after 1 non-last beat -> exactly 4 idle cycles later timeout=1 for 1 cycle, busy=0, a pending req1 is granted next.
REQ-037 Scenario: rst=1 during the 2nd beat of a req1 packet -> next cycle state ARB_IDLE, sel=0, out_valid=0, prio=0.
